// File: rtl/micro_waves_pkg.sv
// Shared types and constants for the microwave cook sequencer.
// State encoding is fixed because the display logic decodes it directly.
package micro_waves_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_COOK  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

    localparam int unsigned MIN_MAX_DEF      = 9;
    localparam int unsigned SEC_TENS_MAX_DEF = 5;

endpackage

// File: rtl/mw_keypad_encoder.sv
// One-hot keypad to BCD digit encoder; valid only when exactly one key is held.
module mw_keypad_encoder
    import micro_waves_pkg::*;
(
    input  logic [9:0] keypad,
    output logic [3:0] digit,
    output logic       valid
);

    logic [3:0] count;

    always_comb begin
        digit = BCD_ZERO;
        count = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                digit = 4'(i);
                count = count + 4'd1;
            end
        end
        valid = (count == 4'd1);
    end

endmodule

// File: rtl/micro_waves_cook_sequencer.sv
// Microwave cook sequencer: keypad M:SS entry, idle/entry/cook/pause FSM and
// BCD countdown on an external 1 Hz enable.
module micro_waves_cook_sequencer
    import micro_waves_pkg::*;
#(
    parameter int unsigned MIN_MAX      = MIN_MAX_DEF,
    parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick_1hz,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state
);

    localparam logic [3:0] MIN_MAX_BCD      = 4'(MIN_MAX);
    localparam logic [3:0] SEC_TENS_MAX_BCD = 4'(SEC_TENS_MAX);

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
    logic       mag_on_q, mag_on_d, done_q, done_d;
    logic       startn_q, stopn_q, clearn_q, key_any_q;

    logic [3:0] key_digit;
    logic       key_valid;

    mw_keypad_encoder u_keypad_encoder (
        .keypad (keypad),
        .digit  (key_digit),
        .valid  (key_valid)
    );

    logic start_ev, stop_ev, clear_ev, key_ev, key_accept;

    assign start_ev = startn_q & ~startn;
    assign stop_ev  = stopn_q & ~stopn;
    assign clear_ev = clearn_q & ~clearn;
    assign key_ev   = key_valid & ~key_any_q;
    // The shift would push sec_ones into sec_tens and sec_tens into minutes.
    assign key_accept = key_ev && (ones_q <= SEC_TENS_MAX_BCD) && (tens_q <= MIN_MAX_BCD);

    logic       time_zero, dec_zero;
    logic [3:0] dec_min, dec_tens, dec_ones;

    assign time_zero = (min_q == BCD_ZERO) && (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);

    always_comb begin
        dec_min  = min_q;
        dec_tens = tens_q;
        dec_ones = ones_q - 4'd1;
        if (ones_q == BCD_ZERO) begin
            dec_ones = BCD_NINE;
            if (tens_q == BCD_ZERO) begin
                dec_tens = SEC_TENS_MAX_BCD;
                dec_min  = (min_q == BCD_ZERO) ? BCD_ZERO : min_q - 4'd1;
            end else begin
                dec_tens = tens_q - 4'd1;
            end
        end
    end

    assign dec_zero = (dec_min == BCD_ZERO) && (dec_tens == BCD_ZERO) && (dec_ones == BCD_ZERO);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_ev) begin
                    {min_d, tens_d, ones_d} = '0;
                end else if (key_accept) begin
                    {min_d, tens_d, ones_d} = {tens_q, ones_q, key_digit};
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (clear_ev || stop_ev) begin
                    {min_d, tens_d, ones_d} = '0;
                    state_d = ST_IDLE;
                end else if (start_ev) begin
                    if (!time_zero && door_closed) state_d = ST_COOK;
                end else if (key_accept) begin
                    {min_d, tens_d, ones_d} = {tens_q, ones_q, key_digit};
                end
            end
            ST_COOK: begin
                if (!door_closed) begin
                    state_d = ST_PAUSE;
                end else if (clear_ev) begin
                    {min_d, tens_d, ones_d} = '0;
                    state_d = ST_IDLE;
                end else if (stop_ev) begin
                    state_d = ST_PAUSE;
                end else if (tick_1hz && !time_zero) begin
                    {min_d, tens_d, ones_d} = {dec_min, dec_tens, dec_ones};
                    if (dec_zero) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear_ev || stop_ev) begin
                    {min_d, tens_d, ones_d} = '0;
                    state_d = ST_IDLE;
                end else if (start_ev && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mag_on_d = (state_d == ST_COOK) && door_closed;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            min_q     <= BCD_ZERO;
            tens_q    <= BCD_ZERO;
            ones_q    <= BCD_ZERO;
            mag_on_q  <= 1'b0;
            done_q    <= 1'b0;
            startn_q  <= 1'b1;
            stopn_q   <= 1'b1;
            clearn_q  <= 1'b1;
            key_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            mag_on_q  <= mag_on_d;
            done_q    <= done_d;
            startn_q  <= startn;
            stopn_q   <= stopn;
            clearn_q  <= clearn;
            key_any_q <= (keypad != 10'd0);
        end
    end

    assign min_bcd      = min_q;
    assign sec_tens_bcd = tens_q;
    assign sec_ones_bcd = ones_q;
    assign mag_on       = mag_on_q;
    assign done         = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_micro_waves_cook_sequencer.sv
// Self-checking bench: directed scenarios plus random button/key/tick traffic
// against a seconds-based reference model of the cook sequencer.
module tb_micro_waves_cook_sequencer;

    localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [9:0] keypad = '0;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
    logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
    logic       mag_on, done;
    logic [1:0] state;

    micro_waves_cook_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .tick_1hz     (tick_1hz),
        .keypad       (keypad),
        .startn       (startn),
        .stopn        (stopn),
        .clearn       (clearn),
        .door_closed  (door_closed),
        .min_bcd      (min_bcd),
        .sec_tens_bcd (sec_tens_bcd),
        .sec_ones_bcd (sec_ones_bcd),
        .mag_on       (mag_on),
        .done         (done),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: time held as digits for entry, counted down in seconds.
    int m_state = S_IDLE;
    int md[3] = '{0, 0, 0};
    bit m_mag = 0, m_done = 0;
    bit p_start = 1, p_stop = 1, p_clear = 1, p_any = 0;

    function automatic int to_secs();
        return md[0] * 60 + md[1] * 10 + md[2];
    endfunction

    task automatic from_secs(input int s);
        md[0] = s / 60;
        md[1] = (s % 60) / 10;
        md[2] = s % 10;
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        md = '{0, 0, 0};
        m_mag = 0; m_done = 0;
        p_start = 1; p_stop = 1; p_clear = 1; p_any = 0;
    endtask

    task automatic model_edge();
        bit any, sev, pev, cev, kev, kacc;
        int kd, nbits, s;
        any = (keypad != 0);
        nbits = 0; kd = 0;
        for (int k = 0; k < 10; k++) if (keypad[k]) begin nbits++; kd = k; end
        kev = any && !p_any && (nbits == 1);
        sev = p_start && !startn;
        pev = p_stop && !stopn;
        cev = p_clear && !clearn;
        p_start = startn; p_stop = stopn; p_clear = clearn; p_any = any;
        kacc = kev && md[2] <= 5 && md[1] <= 9;
        m_done = 0;
        case (m_state)
            S_IDLE: begin
                if (cev) md = '{0, 0, 0};
                else if (kacc) begin md = '{md[1], md[2], kd}; m_state = S_ENTRY; end
            end
            S_ENTRY: begin
                if (cev || pev) begin md = '{0, 0, 0}; m_state = S_IDLE; end
                else if (sev) begin
                    if (to_secs() != 0 && door_closed) m_state = S_COOK;
                end else if (kacc) md = '{md[1], md[2], kd};
            end
            S_COOK: begin
                if (!door_closed) m_state = S_PAUSE;
                else if (cev) begin md = '{0, 0, 0}; m_state = S_IDLE; end
                else if (pev) m_state = S_PAUSE;
                else if (tick_1hz && to_secs() != 0) begin
                    s = to_secs() - 1;
                    from_secs(s);
                    if (s == 0) begin m_done = 1; m_state = S_IDLE; end
                end
            end
            default: begin
                if (cev || pev) begin md = '{0, 0, 0}; m_state = S_IDLE; end
                else if (sev && door_closed) m_state = S_COOK;
            end
        endcase
        m_mag = (m_state == S_COOK) && door_closed;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("state", {2'b00, state}, 4'(m_state));
        chk("min", min_bcd, 4'(md[0]));
        chk("sec_tens", sec_tens_bcd, 4'(md[1]));
        chk("sec_ones", sec_ones_bcd, 4'(md[2]));
        chk("mag_on", {3'b000, mag_on}, {3'b000, m_mag});
        chk("done", {3'b000, done}, {3'b000, m_done});
    endtask

    task automatic step(input logic [9:0] kp, input bit s, input bit p, input bit c,
                        input bit tk);
        keypad = kp; startn = !s; stopn = !p; clearn = !c; tick_1hz = tk;
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(10'd0, 0, 0, 0, 0);
    endtask

    task automatic key(input int k);
        logic [9:0] kp;
        kp = 10'd1 << k;
        step(kp, 0, 0, 0, 0);
        idle(1);
    endtask

    task automatic press_start(); step(10'd0, 1, 0, 0, 0); idle(1); endtask
    task automatic press_stop();  step(10'd0, 0, 1, 0, 0); idle(1); endtask
    task automatic press_clear(); step(10'd0, 0, 0, 1, 0); idle(1); endtask
    task automatic tick();        step(10'd0, 0, 0, 0, 1); idle(1); endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        resetn = 1'b1;
        idle(2);

        // Entry 1,3,0 -> 1:30
        key(1); key(3); key(0);
        chk("entry_min", min_bcd, 4'd1);
        chk("entry_tens", sec_tens_bcd, 4'd3);
        chk("entry_ones", sec_ones_bcd, 4'd0);
        chk("entry_state", {2'b00, state}, 4'd1);

        // 0:03 countdown to done
        press_clear(); press_clear(); key(3); press_start();
        tick(); tick();
        step(10'd0, 0, 0, 0, 1);
        chk("done_pulse", {3'b000, done}, 4'd1);
        chk("done_mag_off", {3'b000, mag_on}, 4'd0);
        idle(1);
        chk("done_one_cycle", {3'b000, done}, 4'd0);

        // Borrow chains
        key(1); key(0); key(0); press_start(); tick();
        chk("borrow_tens", sec_tens_bcd, 4'd5);
        chk("borrow_ones", sec_ones_bcd, 4'd9);
        press_clear(); key(1); key(0); press_start(); tick();
        chk("borrow_10", sec_ones_bcd, 4'd9);
        press_clear();

        // Door open mid-cook, ticks ignored in pause, resume
        key(4); key(5); press_start();
        door_closed = 1'b0; idle(1);
        chk("door_pause", {2'b00, state}, 4'd3);
        tick(); tick();
        door_closed = 1'b1; idle(1);
        press_start(); tick();
        chk("resume_ones", sec_ones_bcd, 4'd4);
        press_clear();

        // Rejected key, multi-key, start at 0:00, start held as one event
        key(7); key(0);
        chk("reject_ones", sec_ones_bcd, 4'd7);
        step(10'h003, 0, 0, 0, 0); idle(1);
        press_clear(); press_start();
        chk("start_zero", {2'b00, state}, 4'd0);
        key(2); key(0); key(0);
        step(10'd0, 1, 0, 0, 0); step(10'd0, 1, 0, 0, 1); step(10'd0, 1, 1, 0, 0);
        step(10'd0, 1, 0, 0, 0); idle(1);
        chk("held_start_paused", {2'b00, state}, 4'd3);
        press_start();

        // Clear and start together while cooking
        step(10'd0, 1, 0, 1, 0); idle(1);
        chk("clear_start_state", {2'b00, state}, 4'd0);

        // Asynchronous reset mid-cook
        key(2); key(0); key(0); press_start(); tick();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(posedge clk); #1;
        chk_all();
        resetn = 1'b1;
        idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: key($urandom_range(0, 9));
                3, 4:    press_start();
                5:       press_stop();
                6:       press_clear();
                7:       begin step(10'(1 << $urandom_range(0, 9)) | 10'h001, 0, 0, 0, 0);
                               idle(1); end
                8:       begin door_closed = ~door_closed; idle(1); end
                default: tick();
            endcase
        end
        door_closed = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
